// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store initiator: FSM states,
// RV32 funct3 width codes and legality rules.
package lsu_pkg;

   typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   function automatic logic [2:0] size_of(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   size_of = 3'd1;
         2'b01:   size_of = 3'd2;
         default: size_of = 3'd4;
      endcase
   endfunction

   function automatic logic legal(input logic is_store, input logic [2:0] f3);
      if (is_store) legal = (f3 inside {F3_B, F3_H, F3_W});
      else          legal = (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
   endfunction

endpackage

// File: rtl/lsu_master_if.sv
// Word-aligned data bus between the load/store initiator and its responders.
interface lsu_master_if #(
   parameter int ADDR_W = 32
) ();
   logic              bus_req;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [31:0]       bus_wdata;
   logic [3:0]        bus_be;
   logic              bus_ready;
   logic [31:0]       bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
      input  bus_ready, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
      output bus_ready, bus_rdata
   );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: store image/byte mask over a two-word window,
// and load extract/extend from the {hi, lo} read pair.
import lsu_pkg::*;

module lsu_align (
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_lo,
   input  logic [31:0] i_hi,
   output logic [63:0] o_image,
   output logic [7:0]  o_mask,
   output logic        o_split,
   output logic [31:0] o_load
);
   logic [2:0]  w_size;
   logic [7:0]  w_lanes;
   logic [4:0]  w_shamt;
   logic [31:0] w_word;

   assign w_size  = size_of(i_funct3);
   assign w_lanes = (8'd1 << w_size) - 8'd1;
   assign w_shamt = {i_off, 3'b000};

   assign o_image = {32'd0, i_wdata} << w_shamt;
   assign o_mask  = w_lanes << i_off;
   assign o_split = ({2'b00, i_off} + {1'b0, w_size}) > 4'd4;

   assign w_word  = 32'({i_hi, i_lo} >> w_shamt);

   always_comb begin
      o_load = w_word;
      case (i_funct3)
         F3_B:    o_load = {{24{w_word[7]}}, w_word[7:0]};
         F3_H:    o_load = {{16{w_word[15]}}, w_word[15:0]};
         F3_BU:   o_load = {24'd0, w_word[7:0]};
         F3_HU:   o_load = {16'd0, w_word[15:0]};
         default: o_load = w_word;
      endcase
   end
endmodule

// File: rtl/lsu_master.sv
// RV32 load/store initiator: one command at a time, split into two word
// transactions when it crosses a word boundary, with per-transaction timeout.
import lsu_pkg::*;

module lsu_master #(
   parameter int TIMEOUT = 16,
   parameter int ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              is_store,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [31:0]       rdata,
   lsu_master_if.master      bus
);
   localparam int CNT_W = $clog2(TIMEOUT);

   lsu_state_e        r_state, w_state_next;
   logic              r_is_store;
   logic [2:0]        r_funct3;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata, r_lo, r_rdata;
   logic              r_err;
   logic [CNT_W-1:0]  r_cnt;

   logic [63:0]       w_image;
   logic [7:0]        w_mask;
   logic              w_split, w_timeout, w_last;
   logic [31:0]       w_load, w_lo, w_hi;
   logic [ADDR_W-1:0] w_word_addr;
   logic              w_req, w_we;
   logic [ADDR_W-1:0] w_addr;
   logic [31:0]       w_wdata;
   logic [3:0]        w_be;

   assign w_word_addr = {r_addr[ADDR_W-1:2], 2'b00};

   // The final read word goes straight into the extractor so rdata registers on RESP entry.
   assign w_lo = (r_state == ACC1) ? r_lo : bus.bus_rdata;
   assign w_hi = (r_state == ACC1) ? bus.bus_rdata : '0;

   lsu_align u_align (
      .i_funct3 (r_funct3),
      .i_off    (r_addr[1:0]),
      .i_wdata  (r_wdata),
      .i_lo     (w_lo),
      .i_hi     (w_hi),
      .o_image  (w_image),
      .o_mask   (w_mask),
      .o_split  (w_split),
      .o_load   (w_load)
   );

   always_comb begin
      w_state_next = r_state;
      w_req        = 1'b0;
      w_we         = 1'b0;
      w_addr       = '0;
      w_wdata      = '0;
      w_be         = '0;
      w_timeout    = 1'b0;
      w_last       = 1'b0;
      unique case (r_state)
         IDLE: if (start) w_state_next = legal(is_store, funct3) ? ACC0 : RESP;
         ACC0: begin
            w_req   = 1'b1;
            w_we    = r_is_store;
            w_addr  = w_word_addr;
            w_be    = w_mask[3:0];
            w_wdata = w_image[31:0];
            if (bus.bus_ready) begin
               w_state_next = w_split ? ACC1 : RESP;
               w_last       = !w_split;
            end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
               w_state_next = RESP;
               w_timeout    = 1'b1;
            end
         end
         ACC1: begin
            w_req   = 1'b1;
            w_we    = r_is_store;
            w_addr  = w_word_addr + ADDR_W'(4);
            w_be    = w_mask[7:4];
            w_wdata = w_image[63:32];
            if (bus.bus_ready) begin
               w_state_next = RESP;
               w_last       = 1'b1;
            end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
               w_state_next = RESP;
               w_timeout    = 1'b1;
            end
         end
         RESP:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_is_store <= 1'b0;
         r_funct3   <= '0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_lo       <= '0;
         r_rdata    <= '0;
         r_err      <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_state_next != r_state || !(r_state inside {ACC0, ACC1}))
            r_cnt <= '0;
         else
            r_cnt <= r_cnt + CNT_W'(1);
         if (r_state == IDLE && start) begin
            r_is_store <= is_store;
            r_funct3   <= funct3;
            r_addr     <= addr;
            r_wdata    <= wdata;
            r_err      <= !legal(is_store, funct3);
         end
         if (r_state == ACC0 && bus.bus_ready) r_lo <= bus.bus_rdata;
         if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
         end else if (w_last && !r_is_store) begin
            r_rdata <= w_load;
         end
      end
   end

   assign busy  = (r_state != IDLE);
   assign done  = (r_state == RESP);
   assign err   = done & r_err;
   assign rdata = r_rdata;

   assign bus.bus_req   = w_req;
   assign bus.bus_we    = w_we;
   assign bus.bus_addr  = w_addr;
   assign bus.bus_wdata = w_wdata;
   assign bus.bus_be    = w_be;
endmodule

// File: tb/tb_lsu_master.sv
// Directed bench for lsu_master: a scripted responder answers requests with
// fixed words and programmable ready delay; results are checked against hand values.
module tb_lsu_master;
   logic        clk;
   logic        reset;
   logic        start;
   logic        is_store;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy, done, err;
   logic [31:0] rdata;

   lsu_master_if #(.ADDR_W(32)) bus ();

   lsu_master #(.TIMEOUT(16), .ADDR_W(32)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .is_store (is_store),
      .funct3   (funct3),
      .addr     (addr),
      .wdata    (wdata),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .rdata    (rdata),
      .bus      (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] tr_addr  [4];
   logic [31:0] tr_wdata [4];
   logic [3:0]  tr_be    [4];
   logic        tr_we    [4];
   int          n_tr, n_req, lat, unstable;
   logic        seen, obs_err, obs_req;
   logic [31:0] obs_rdata;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Issues one command, then plays responder until done (bounded).
   task automatic run(input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input int dly, input bit never,
                      input logic [31:0] rd0, input logic [31:0] rd1);
      int wait_c;
      wait_c = 0; n_tr = 0; n_req = 0; unstable = 0; seen = 1'b0; lat = 1;
      @(posedge clk); #1;
      start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
      for (int k = 0; k < 60 && !seen; k++) begin
         @(posedge clk); #1;
         start = 1'b0;
         lat++;
         if (done) begin
            seen = 1'b1; obs_rdata = rdata; obs_err = err; obs_req = bus.bus_req;
            bus.bus_ready = 1'b0;
         end else if (bus.bus_req) begin
            n_req++;
            if (n_tr < 4) begin
               if (wait_c == 0) begin
                  tr_addr[n_tr] = bus.bus_addr; tr_wdata[n_tr] = bus.bus_wdata;
                  tr_be[n_tr] = bus.bus_be;     tr_we[n_tr] = bus.bus_we;
               end else if (bus.bus_addr !== tr_addr[n_tr] || bus.bus_wdata !== tr_wdata[n_tr] ||
                            bus.bus_be !== tr_be[n_tr] || bus.bus_we !== tr_we[n_tr]) begin
                  unstable++;
               end
            end
            if (!never && wait_c >= dly) begin
               bus.bus_ready = 1'b1;
               bus.bus_rdata = (n_tr == 0) ? rd0 : rd1;
               n_tr++; wait_c = 0;
            end else begin
               bus.bus_ready = 1'b0;
               bus.bus_rdata = 32'hDEADDEAD;
               wait_c++;
            end
         end else begin
            bus.bus_ready = 1'b0;
         end
      end
      check("done_seen", {31'd0, seen}, 32'd1);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
      addr = '0; wdata = '0; bus.bus_ready = 1'b0; bus.bus_rdata = '0;
      #1;
      check("rst_busy",  {31'd0, busy}, 32'd0);
      check("rst_done",  {31'd0, done}, 32'd0);
      check("rst_err",   {31'd0, err}, 32'd0);
      check("rst_req",   {31'd0, bus.bus_req}, 32'd0);
      check("rst_we",    {31'd0, bus.bus_we}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_addr",  bus.bus_addr, 32'd0);
      check("rst_be",    {28'd0, bus.bus_be}, 32'd0);
      check("rst_wdata", bus.bus_wdata, 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // SW 0x12345678 -> 0x100
      run(1'b1, 3'b010, 32'h100, 32'h12345678, 0, 1'b0, 32'h0, 32'h0);
      check("sw_ntr",   n_tr, 1);
      check("sw_addr",  tr_addr[0], 32'h100);
      check("sw_be",    {28'd0, tr_be[0]}, 32'hF);
      check("sw_we",    {31'd0, tr_we[0]}, 32'd1);
      check("sw_wdata", tr_wdata[0], 32'h12345678);
      check("sw_lat",   lat, 3);
      check("sw_err",   {31'd0, obs_err}, 32'd0);
      check("sw_req_in_resp", {31'd0, obs_req}, 32'd0);
      @(posedge clk); #1;
      check("sw_done_pulse", {31'd0, done}, 32'd0);
      check("sw_busy_after", {31'd0, busy}, 32'd0);

      // SB 0xAB -> 0x102
      run(1'b1, 3'b000, 32'h102, 32'h000000AB, 0, 1'b0, 32'h0, 32'h0);
      check("sb_be",    {28'd0, tr_be[0]}, 32'h4);
      check("sb_wdata", tr_wdata[0], 32'h00AB0000);
      check("sb_lat",   lat, 3);

      // LH at 0x103, split
      run(1'b0, 3'b001, 32'h103, 32'h0, 0, 1'b0, 32'h80FFFFFF, 32'h000000FF);
      check("lh_ntr",   n_tr, 2);
      check("lh_addr0", tr_addr[0], 32'h100);
      check("lh_be0",   {28'd0, tr_be[0]}, 32'h8);
      check("lh_addr1", tr_addr[1], 32'h104);
      check("lh_be1",   {28'd0, tr_be[1]}, 32'h1);
      check("lh_we",    {31'd0, tr_we[0]}, 32'd0);
      check("lh_rdata", obs_rdata, 32'hFFFFFF80);
      check("lh_lat",   lat, 4);

      // LW at 0x202, ready delayed 3 cycles per transaction
      run(1'b0, 3'b010, 32'h202, 32'h0, 3, 1'b0, 32'h4433BEEF, 32'hDEAD6655);
      check("lw_rdata",  obs_rdata, 32'h66554433);
      check("lw_stable", unstable, 0);
      check("lw_be0",    {28'd0, tr_be[0]}, 32'hC);
      check("lw_be1",    {28'd0, tr_be[1]}, 32'h3);
      check("lw_lat",    lat, 10);
      check("lw_err",    {31'd0, obs_err}, 32'd0);

      // Store leaves rdata untouched
      run(1'b1, 3'b001, 32'h400, 32'h0000BEEF, 0, 1'b0, 32'h0, 32'h0);
      check("st_hold_rdata", obs_rdata, 32'h66554433);

      // LHU at 0xFFFFFFFF: second word address wraps to 0
      run(1'b0, 3'b101, 32'hFFFFFFFF, 32'h0, 0, 1'b0, 32'hAA112233, 32'h445566BB);
      check("wrap_addr0", tr_addr[0], 32'hFFFFFFFC);
      check("wrap_addr1", tr_addr[1], 32'h00000000);
      check("wrap_rdata", obs_rdata, 32'h0000BBAA);

      // LBU, ready arrives on the last allowed cycle: completes normally
      run(1'b0, 3'b100, 32'h301, 32'h0, 15, 1'b0, 32'h00008000, 32'h0);
      check("late_err",   {31'd0, obs_err}, 32'd0);
      check("late_rdata", obs_rdata, 32'h00000080);
      check("late_lat",   lat, 18);

      // LBU at 0x300, ready never: timeout
      run(1'b0, 3'b100, 32'h300, 32'h0, 0, 1'b1, 32'h0, 32'h0);
      check("to_err",   {31'd0, obs_err}, 32'd1);
      check("to_rdata", obs_rdata, 32'h0);
      check("to_lat",   lat, 18);
      check("to_nreq",  n_req, 16);

      // Illegal funct3: load 011, store 100
      run(1'b0, 3'b011, 32'h500, 32'h0, 0, 1'b0, 32'h0, 32'h0);
      check("ill_ld_nreq", n_req, 0);
      check("ill_ld_err",  {31'd0, obs_err}, 32'd1);
      check("ill_ld_lat",  lat, 2);
      run(1'b1, 3'b100, 32'h500, 32'h0, 0, 1'b0, 32'h0, 32'h0);
      check("ill_st_nreq", n_req, 0);
      check("ill_st_err",  {31'd0, obs_err}, 32'd1);

      // Reset asserted mid-ACC1
      @(posedge clk); #1;
      start = 1'b1; is_store = 1'b0; funct3 = 3'b001; addr = 32'h103;
      @(posedge clk); #1;
      start = 1'b0; bus.bus_ready = 1'b1; bus.bus_rdata = 32'h11223344;
      @(posedge clk); #1;
      bus.bus_ready = 1'b0;
      check("acc1_req",  {31'd0, bus.bus_req}, 32'd1);
      check("acc1_addr", bus.bus_addr, 32'h104);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_req",  {31'd0, bus.bus_req}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_be",   {28'd0, bus.bus_be}, 32'd0);
      @(posedge clk); #1 reset = 1'b0;
      run(1'b0, 3'b010, 32'h100, 32'h0, 0, 1'b0, 32'hCAFEF00D, 32'h0);
      check("post_rst_rdata", obs_rdata, 32'hCAFEF00D);
      check("post_rst_lat",   lat, 3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
